// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one handshaked memory port between fetch (p0) and data (p1).
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties; default is fixed p1 priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_p0_req,
    input  logic                  i_p1_req,
    input  logic                  i_p0_we,
    input  logic                  i_p1_we,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,
    output logic                  o_p0_done,
    output logic                  o_p1_done,
    output logic                  o_mem_write_en,
    output logic                  o_mem_read_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_access,
    output logic [1:0]            o_grant,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                state_q;
    logic                  we_q;
    logic                  port_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [1:0]            grant_q;
    logic                  busy_q;
    logic                  rd_q;
    logic                  wr_q;
    logic                  done0_q;
    logic                  done1_q;

    logic                  win_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Last granted port; reset to p1 so p0 wins the first tie.
    logic last_q;

    // Tie goes to the port not granted last; a lone requester always wins.
    always_comb begin
        win_d = i_p1_req;
        if (i_p0_req && i_p1_req) begin
            win_d = ~last_q;
        end
    end

    // Pointer follows every grant.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_q <= 1'b1;
        end else if (state_q == S_IDLE && (i_p0_req || i_p1_req)) begin
            last_q <= win_d;
        end
    end
`else
    // Fixed priority: the data port always beats instruction fetch.
    always_comb begin
        win_d = i_p1_req;
    end
`endif

    // Select the winner's request fields for latching.
    always_comb begin
        we_d    = win_d ? i_p1_we    : i_p0_we;
        addr_d  = win_d ? i_p1_addr  : i_p0_addr;
        wdata_d = win_d ? i_p1_wdata : i_p0_wdata;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            port_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            grant_q  <= 2'b00;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_p0_req || i_p1_req) begin
                        port_q  <= win_d;
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        grant_q <= win_d ? 2'b10 : 2'b01;
                        busy_q  <= 1'b1;
                        rd_q    <= ~we_d;
                        wr_q    <= we_d;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (i_mem_access) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        done0_q <= ~port_q;
                        done1_q <= port_q;
                        if (!we_q && port_q) begin
                            rdata1_q <= i_mem_rdata;
                        end
                        if (!we_q && !port_q) begin
                            rdata0_q <= i_mem_rdata;
                        end
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_p0_rdata     = rdata0_q;
    assign o_p1_rdata     = rdata1_q;
    assign o_p0_done      = done0_q;
    assign o_p1_done      = done1_q;
    assign o_mem_write_en = wr_q;
    assign o_mem_read_req = rd_q;
    assign o_mem_addr     = addr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_grant        = grant_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Memory model completes after a programmable number of request cycles.
module tb_mem_arbiter;

    logic        clk;
    logic        arst_n;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done;
    logic        mem_we, mem_rd;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_acc;
    logic [1:0]  grant;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:63];
    int          cnt;
    int          lat;
    logic        force_acc;
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    mem_arbiter dut (
        .clk(clk), .arst_n(arst_n),
        .i_p0_req(p0_req), .i_p1_req(p1_req),
        .i_p0_we(p0_we), .i_p1_we(p1_we),
        .i_p0_addr(p0_addr), .i_p1_addr(p1_addr),
        .i_p0_wdata(p0_wdata), .i_p1_wdata(p1_wdata),
        .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata),
        .o_p0_done(p0_done), .o_p1_done(p1_done),
        .o_mem_write_en(mem_we), .o_mem_read_req(mem_rd),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_access(mem_acc),
        .o_grant(grant), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_acc = force_acc | ((mem_rd | mem_we) && (cnt == lat - 1));
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we && mem_acc) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_rd | mem_we) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic wait_done(input bit port, output int rd_hi, output int wr_hi,
                             output bit ovl, output bit to,
                             output logic [1:0] g_first);
        rd_hi = 0; wr_hi = 0; ovl = 0; to = 1; g_first = 2'b00;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) g_first = grant;
            if (port ? p1_done : p0_done) begin
                to = 0;
                break;
            end
            rd_hi += int'(mem_rd);
            wr_hi += int'(mem_we);
            if (mem_rd && mem_we) ovl = 1;
        end
    endtask

    task automatic wait_any(output bit to, output logic [1:0] g);
        to = 1; g = 2'b00;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (p0_done || p1_done) begin
                to = 0;
                g = grant;
                break;
            end
        end
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if ({mem_rd, mem_we} !== 2'b00) begin bad++; $display("FAIL rst_memreq got=%b exp=00", {mem_rd, mem_we}); end
        total++; if ({p0_done, p1_done} !== 2'b00) begin bad++; $display("FAIL rst_done got=%b exp=00", {p0_done, p1_done}); end
        total++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0", p0_rdata, p1_rdata); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_memaddr got=%h/%h exp=0", mem_addr, mem_wdata); end
        arst_n = 1'b1;
    endtask

    task automatic test_p0_read;
        int rh, wh; bit ov, to; logic [1:0] g;
        preload(6'd4, 32'hDEAD_BEEF);
        lat = 22;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        wait_done(1'b0, rh, wh, ov, to, g);
        p0_req = 1'b0;
        total++; if (to !== 1'b0) begin bad++; $display("FAIL p0rd_timeout got=%b exp=0", to); end
        total++; if (g !== 2'b01) begin bad++; $display("FAIL p0rd_grant got=%b exp=01", g); end
        total++; if (rh !== 22 || wh !== 0) begin bad++; $display("FAIL p0rd_cycles got=%0d/%0d exp=22/0", rh, wh); end
        total++; if (p0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL p0rd_data got=%h exp=deadbeef", p0_rdata); end
        @(negedge clk);
        total++; if (p0_done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL p0rd_pulse got=%b%b exp=00", p0_done, busy); end
    endtask

    task automatic test_p1_write_read;
        int rh, wh; bit ov, to; logic [1:0] g;
        lat = 3;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = 32'h1234_5678;
        wait_done(1'b1, rh, wh, ov, to, g);
        p1_req = 1'b0; p1_we = 1'b0;
        total++; if (to !== 1'b0 || g !== 2'b10) begin bad++; $display("FAIL p1wr_grant got=%b/%b exp=0/10", to, g); end
        total++; if (wh !== 3 || rh !== 0 || ov !== 1'b0) begin bad++; $display("FAIL p1wr_req got=%0d/%0d/%b exp=3/0/0", wh, rh, ov); end
        total++; if (mem[16] !== 32'h1234_5678) begin bad++; $display("FAIL p1wr_mem got=%h exp=12345678", mem[16]); end
        @(negedge clk);
        p1_req = 1'b1;
        wait_done(1'b1, rh, wh, ov, to, g);
        p1_req = 1'b0;
        total++; if (to !== 1'b0 || rh !== 3 || wh !== 0 || ov !== 1'b0) begin bad++; $display("FAIL p1rd_req got=%b/%0d/%0d/%b exp=0/3/0/0", to, rh, wh, ov); end
        total++; if (p1_rdata !== 32'h1234_5678) begin bad++; $display("FAIL p1rd_data got=%h exp=12345678", p1_rdata); end
        total++; if (p0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL p0_hold got=%h exp=deadbeef", p0_rdata); end
        @(negedge clk);
    endtask

    task automatic test_tie;
        bit to; logic [1:0] g;
        logic [1:0] exp [0:3];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10;
`else
        exp[0] = 2'b10; exp[1] = 2'b10; exp[2] = 2'b10; exp[3] = 2'b10;
`endif
        lat = 2;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h40;
        for (int k = 0; k < 4; k++) begin
            wait_any(to, g);
            if (k == 3) p1_req = 1'b0;
            total++; if (to !== 1'b0 || g !== exp[k]) begin bad++; $display("FAIL tie_grant%0d got=%b/%b exp=0/%b", k, to, g, exp[k]); end
        end
        wait_any(to, g);
        p0_req = 1'b0;
        total++; if (to !== 1'b0 || g !== 2'b01) begin bad++; $display("FAIL tie_single got=%b/%b exp=0/01", to, g); end
        @(negedge clk);
    endtask

    task automatic test_freeze_back_to_back;
        int rh, wh; bit ov, to; logic [1:0] g;
        int moved = 0;
        bit seen = 0;
        lat = 4;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'hA5A5_0001;
        @(negedge clk);
        p0_addr = 32'h24; p0_wdata = 32'hFFFF_FFFF;
        if (mem_addr !== 32'h20 || mem_wdata !== 32'hA5A5_0001) moved++;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (p0_done) begin
                seen = 1;
                break;
            end
            if (mem_addr !== 32'h20 || mem_wdata !== 32'hA5A5_0001) moved++;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL frz_timeout got=%b exp=1", seen); end
        total++; if (moved !== 0) begin bad++; $display("FAIL frz_latch got=%0d exp=0", moved); end
        total++; if (mem[8] !== 32'hA5A5_0001) begin bad++; $display("FAIL frz_mem got=%h exp=a5a50001", mem[8]); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=0/00", busy, grant); end
        @(negedge clk);
        total++; if (grant !== 2'b01 || mem_we !== 1'b1 || mem_addr !== 32'h24) begin bad++; $display("FAIL b2b_regrant got=%b/%b/%h exp=01/1/24", grant, mem_we, mem_addr); end
        p0_req = 1'b0;
        wait_done(1'b0, rh, wh, ov, to, g);
        p0_we = 1'b0;
        total++; if (to !== 1'b0 || wh !== 3) begin bad++; $display("FAIL b2b_done got=%b/%0d exp=0/3", to, wh); end
        total++; if (mem[9] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_mem got=%h exp=ffffffff", mem[9]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int rh, wh; bit ov, to; logic [1:0] g;
        int dn = 0;
        preload(6'd4, 32'hCAFE_F00D);
        lat = 10;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        repeat (3) @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        total++; if (grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL amid_grant got=%b/%b exp=00/0", grant, busy); end
        total++; if ({mem_rd, mem_we} !== 2'b00) begin bad++; $display("FAIL amid_memreq got=%b exp=00", {mem_rd, mem_we}); end
        total++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin bad++; $display("FAIL amid_rdata got=%h/%h exp=0", p0_rdata, p1_rdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (p0_done || p1_done || busy) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL amid_nodone got=%0d exp=0", dn); end
        arst_n = 1'b1;
        wait_done(1'b0, rh, wh, ov, to, g);
        p0_req = 1'b0;
        total++; if (to !== 1'b0 || g !== 2'b01 || rh !== 10) begin bad++; $display("FAIL amid_restart got=%b/%b/%0d exp=0/01/10", to, g, rh); end
        total++; if (p0_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL amid_data got=%h exp=cafef00d", p0_rdata); end
        @(negedge clk);
    endtask

    task automatic test_idle_access;
        int rh, wh; bit ov, to; logic [1:0] g;
        int hits = 0;
        force_acc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy || p0_done || p1_done || grant != 2'b00) hits++;
        end
        force_acc = 1'b0;
        total++; if (hits !== 0) begin bad++; $display("FAIL idle_acc got=%0d exp=0", hits); end
        lat = 1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h40;
        wait_done(1'b0, rh, wh, ov, to, g);
        p0_req = 1'b0;
        total++; if (to !== 1'b0 || rh !== 1 || g !== 2'b01) begin bad++; $display("FAIL idle_min got=%b/%0d/%b exp=0/1/01", to, rh, g); end
        total++; if (p0_rdata !== 32'h1234_5678) begin bad++; $display("FAIL idle_data got=%h exp=12345678", p0_rdata); end
        @(negedge clk);
    endtask

    task automatic test_ptr_reset;
        bit to; logic [1:0] g;
        logic [1:0] e;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        e = 2'b01;
`else
        e = 2'b10;
`endif
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        lat = 2;
        p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
        wait_any(to, g);
        p0_req = 1'b0; p1_req = 1'b0;
        total++; if (to !== 1'b0 || g !== e) begin bad++; $display("FAIL ptr_reset got=%b/%b exp=0/%b", to, g, e); end
        @(negedge clk);
    endtask

    initial begin
        arst_n = 1'b0;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        lat = 1; force_acc = 0; pre_we = 0; pre_addr = 0; pre_data = 0;
        test_reset();
        test_p0_read();
        test_p1_write_read();
        test_tie();
        test_freeze_back_to_back();
        test_reset_mid();
        test_idle_access();
        test_ptr_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
